// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: collects 8 streaming complex samples into a frame and
// hands them to the 8-point FFT core in natural order with a one-cycle fft_en.
// Frames that are misaligned with s_last are dropped. After a missing last,
// the block waits in SEEK for the next s_last before collecting again.
module fft8_frame_loader #(
  parameter int DW         = 24,
  parameter bit CHECK_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          run,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_real,
  input  logic [DW-1:0] s_imag,
  input  logic          s_last,
  output logic          fft_en,
  output logic [DW-1:0] x0_real,
  output logic [DW-1:0] x1_real,
  output logic [DW-1:0] x2_real,
  output logic [DW-1:0] x3_real,
  output logic [DW-1:0] x4_real,
  output logic [DW-1:0] x5_real,
  output logic [DW-1:0] x6_real,
  output logic [DW-1:0] x7_real,
  output logic [DW-1:0] x0_imag,
  output logic [DW-1:0] x1_imag,
  output logic [DW-1:0] x2_imag,
  output logic [DW-1:0] x3_imag,
  output logic [DW-1:0] x4_imag,
  output logic [DW-1:0] x5_imag,
  output logic [DW-1:0] x6_imag,
  output logic [DW-1:0] x7_imag,
  output logic          frame_err,
  output logic [15:0]   err_cnt,
  output logic          busy
);

  typedef enum logic {COLLECT, SEEK} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [DW-1:0] frame_real [8];
  logic [DW-1:0] frame_imag [8];
  logic [DW-1:0] out_real [8];
  logic [DW-1:0] out_imag [8];
  logic          hs;
  logic          last_ok;
  logic          err_event;

  // Handshake, alignment check and error detection. The s_ready term is
  // gated by rstn so that the source sees no acceptance while reset is held.
  always_comb begin
    s_ready   = run & rstn;
    hs        = s_valid & s_ready;
    last_ok   = !CHECK_LAST || s_last;
    busy      = (idx != 3'd0) || (state == SEEK);
    err_event = 1'b0;
    if (!flush && hs && (state == COLLECT) && CHECK_LAST) begin
      if (idx != 3'd7)
        err_event = s_last;
      else
        err_event = !s_last;
    end
  end

  // Frame collection FSM, dispatch into the output registers and error pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= COLLECT;
      idx       <= 3'd0;
      fft_en    <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        frame_real[i] <= '0;
        frame_imag[i] <= '0;
        out_real[i]   <= '0;
        out_imag[i]   <= '0;
      end
    end else begin
      fft_en    <= 1'b0;
      frame_err <= err_event;
      if (flush) begin
        idx   <= 3'd0;
        state <= COLLECT;
      end else if (hs) begin
        if (state == COLLECT) begin
          frame_real[idx] <= s_real;
          frame_imag[idx] <= s_imag;
          if (idx != 3'd7) begin
            if (CHECK_LAST && s_last)
              idx <= 3'd0;
            else
              idx <= idx + 3'd1;
          end else if (last_ok) begin
            for (int i = 0; i < 7; i++) begin
              out_real[i] <= frame_real[i];
              out_imag[i] <= frame_imag[i];
            end
            out_real[7] <= s_real;
            out_imag[7] <= s_imag;
            fft_en      <= 1'b1;
            idx         <= 3'd0;
          end else begin
            idx   <= 3'd0;
            state <= SEEK;
          end
        end else if (s_last) begin
          state <= COLLECT;
          idx   <= 3'd0;
        end
      end
    end
  end

  // Saturating error counter, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      err_cnt <= 16'd0;
    else if (err_event && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end

  assign x0_real = out_real[0];
  assign x1_real = out_real[1];
  assign x2_real = out_real[2];
  assign x3_real = out_real[3];
  assign x4_real = out_real[4];
  assign x5_real = out_real[5];
  assign x6_real = out_real[6];
  assign x7_real = out_real[7];
  assign x0_imag = out_imag[0];
  assign x1_imag = out_imag[1];
  assign x2_imag = out_imag[2];
  assign x3_imag = out_imag[3];
  assign x4_imag = out_imag[4];
  assign x5_imag = out_imag[5];
  assign x6_imag = out_imag[6];
  assign x7_imag = out_imag[7];

endmodule

// File: doc/fft8_frame_loader.md
Name: fft8_frame_loader

Overview:
- Streaming front end for the 8-point FFT core. Accepts one complex sample per valid/ready handshake, collects 8 consecutive samples into a frame, and presents them in parallel on x0..x7 in natural order, together with a single-cycle fft_en pulse.
- Bit reversal is performed inside the FFT core, so this block does not reorder samples.
- Checks frame alignment against s_last. Drops misaligned frames and resynchronises on the next s_last.

Parameters:
- DW, 24, sample width of each real/imag component (signed two's complement).
- CHECK_LAST, 1: 1 = s_last must mark sample 7 of every frame; 0 = s_last ignored and frames are counted purely by index.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous, active-low.
- run  input  1  level; 1 = accept samples.
- flush  input  1  synchronous pulse; discards any partial frame.
- s_valid  input  1  sample valid.
- s_ready  output  1  sample ready.
- s_real  input  DW  sample real part.
- s_imag  input  DW  sample imag part.
- s_last  input  1  marks the last sample of a frame.
- fft_en  output  1  one-cycle frame strobe to the FFT core en input.
- x0_real..x7_real  output  DW each  frame real parts; xN = Nth accepted sample.
- x0_imag..x7_imag  output  DW each  frame imag parts.
- frame_err  output  1  one-cycle pulse on alignment error.
- err_cnt  output  16  saturating count of frame_err pulses.
- busy  output  1  1 when a partial frame is held or the block is in SEEK.

Behaviour:
- Reset values: all x*, fft_en, frame_err, err_cnt, s_ready = 0; state = COLLECT; idx = 0; collection buffer = 0.
- Combinational outputs: s_ready = run (combinational after reset; 0 while rstn low). Handshake hs = s_valid & s_ready. busy = (idx != 0) | (state == SEEK).

State COLLECT, on hs (flush low):
- buf[idx] <= sample.
- If idx < 7 and (CHECK_LAST = 0 or s_last = 0): idx <= idx + 1.
- If idx < 7 and CHECK_LAST = 1 and s_last = 1 (early last): partial frame discarded, idx <= 0, frame_err pulse, stay in COLLECT.
- If idx == 7 and (CHECK_LAST = 0 or s_last = 1): dispatch. Output registers load buf[0..6] plus the current sample as x7 on the same edge; fft_en = 1 in the following cycle only; idx <= 0.
- If idx == 7 and CHECK_LAST = 1 and s_last = 0 (missing last): frame discarded, frame_err pulse, idx <= 0, state <= SEEK.

State SEEK:
- Every hs sample is dropped.
- A hs with s_last = 1 sets state <= COLLECT and idx <= 0; no error pulse is raised here.

Timing and output rules:
- Latency: fft_en is asserted 1 cycle after the clock edge of the 8th handshake. x0..x7 change only on that same edge and hold until the next dispatch.
- Back-to-back frames are legal at full rate. fft_en may assert every 8 cycles; the core needs no backpressure.

Flush:
- flush = 1 sets idx <= 0 and state <= COLLECT. It has priority over a simultaneous hs, which is dropped.
- No frame_err pulse.
- x* and a pending fft_en are unaffected.

run:
- run = 0 stalls collection; idx and the buffer are retained.
- A dispatch already scheduled still fires.

err_cnt:
- Increments with each frame_err pulse and saturates at 16'hFFFF.
- Cleared only by reset.

Reset mid-frame:
- All state is cleared immediately and asynchronously.
- fft_en is never asserted for a partial frame.

Test Plan:
1. run = 1; stream samples k = 0..7 with real = k+1, imag = -(k+1), s_last on k = 7, continuous valid -> fft_en high exactly once, 1 cycle after the 8th handshake; x0_real = 1 ... x7_real = 8; x7_imag = -8; err_cnt = 0.
2. 3 frames back-to-back (24 samples, no gaps) with random s_valid bubbles -> exactly 3 fft_en pulses; each x* set matches its frame; outputs stable between pulses.
3. s_last on the 5th sample -> frame_err pulse, err_cnt = 1, no fft_en; the next 8-sample frame dispatches correctly.
4. 8 samples without s_last, then 3 extra samples with s_last on the 3rd, then a good frame -> frame_err once; the 11 samples are dropped; busy = 1 through SEEK; only the good frame dispatches.
5. 4 samples, then flush coincident with a valid handshake, then a full frame -> dropped sample absent; x0 = first sample after flush; no frame_err.
6. rstn low after 6 samples, then release and send a full frame -> all outputs 0 during reset; s_ready = 0 while rstn is low; a single fft_en for the new frame. Separately, force 65540 errors -> err_cnt holds at 16'hFFFF.
